// File: rtl/debug_pkg.sv
// Shared constants for the UART debug command engine: opcode and response bytes,
// the controller state encoding and a word-size helper.
package debug_pkg;

  localparam logic [7:0] OP_LOAD   = 8'h4C;
  localparam logic [7:0] OP_RUN    = 8'h52;
  localparam logic [7:0] OP_STEP   = 8'h53;
  localparam logic [7:0] OP_DUMP   = 8'h44;
  localparam logic [7:0] OP_CPURST = 8'h58;
  localparam logic [7:0] OP_BREAK  = 8'h42;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WRITE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_ADDR,
    ST_DUMP_LOAD,
    ST_DUMP_BYTE,
    ST_DUMP_WAIT,
    ST_RESP,
    ST_RESP_WAIT
  } state_t;

  function automatic int word_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Word-wide shift register with a byte counter: shifts bytes out LSB first for dumps,
// or assembles incoming bytes LSB first when shift_in_mode is set.
module dbg_word_serializer
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  shift,
  input  logic                  shift_in_mode,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic [7:0]            byte_out,
  output logic                  last_byte
);

  localparam int WB = word_bytes(DATA_WIDTH);
  localparam int CW = (WB > 1) ? $clog2(WB) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH+7:0] shift_in_ext;

  assign word_out  = word_q;
  assign byte_out  = word_q[7:0];
  assign last_byte = (cnt_q == CW'(WB - 1));

  // New bytes enter at the top so the first byte received ends up in the LSB.
  always_comb begin
    word_d       = word_q;
    cnt_d        = cnt_q;
    shift_in_ext = {byte_in, word_q} >> 8;
    if (load) begin
      word_d = load_word;
      cnt_d  = '0;
    end else if (shift) begin
      if (shift_in_mode) begin
        word_d = shift_in_ext[DATA_WIDTH-1:0];
      end else begin
        word_d = word_q >> 8;
      end
      cnt_d = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_cmd_engine.sv
// Byte-serial debug command engine: loads instruction memory, runs/steps the CPU and
// dumps PC, cycle count, registers and a data-memory window back over the UART.
module debug_cmd_engine
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IM_ADDR_WIDTH = 10,
  parameter int RBITS         = 5,
  parameter int RB_SIZE       = 32,
  parameter int DM_ADDR_WIDTH = 10,
  parameter int DM_DUMP       = 16,
  parameter int PC_WIDTH      = 32,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     tx_done,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     halt_flag,
  input  logic [PC_WIDTH-1:0]      current_pc,
  input  logic [CNT_WIDTH-1:0]     clock_count,
  input  logic [DATA_WIDTH-1:0]    rb_data,
  input  logic [DATA_WIDTH-1:0]    dm_data,
  output logic [IM_ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0]    im_data,
  output logic                     im_we,
  output logic [RBITS-1:0]         rb_addr,
  output logic [DM_ADDR_WIDTH-1:0] dm_addr,
  output logic                     cpu_enable,
  output logic                     cpu_rst
);

  localparam int N_ITEMS = 2 + RB_SIZE + DM_DUMP;
  localparam int IW      = $clog2(N_ITEMS + 1);

  state_t                state_q, state_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [7:0]            word_idx_q, word_idx_d;
  logic                  nak_q, nak_d;
  logic [7:0]            resp_q, resp_d;
  logic [IW-1:0]         item_q, item_d;
  logic [DATA_WIDTH-1:0] pc_snap_q, pc_snap_d;
  logic [DATA_WIDTH-1:0] cnt_snap_q, cnt_snap_d;
  logic                  cpu_rst_q, cpu_rst_d;

  logic                  ser_load, ser_shift, ser_shift_in, ser_last;
  logic [DATA_WIDTH-1:0] ser_load_word, ser_word;
  logic [7:0]            ser_byte;
  logic                  idx_in_range, item_is_rb, item_is_dm, addr_phase;

  dbg_word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk          (clk),
    .rst          (rst),
    .load         (ser_load),
    .load_word    (ser_load_word),
    .shift        (ser_shift),
    .shift_in_mode(ser_shift_in),
    .byte_in      (rx_data),
    .word_out     (ser_word),
    .byte_out     (ser_byte),
    .last_byte    (ser_last)
  );

  // Word indices past the top of instruction memory are swallowed and flagged.
  assign idx_in_range = ((32'(word_idx_q) >> IM_ADDR_WIDTH) == 32'd0);
  assign item_is_rb   = (int'(item_q) >= 2) && (int'(item_q) < 2 + RB_SIZE);
  assign item_is_dm   = (int'(item_q) >= 2 + RB_SIZE);
  assign addr_phase   = (state_q == ST_DUMP_ADDR) || (state_q == ST_DUMP_LOAD);

  assign rb_addr = (addr_phase && item_is_rb) ? RBITS'(item_q - IW'(2)) : '0;
  assign dm_addr = (addr_phase && item_is_dm) ? DM_ADDR_WIDTH'(item_q - IW'(2 + RB_SIZE)) : '0;
  assign im_addr = IM_ADDR_WIDTH'(word_idx_q);
  assign im_data = ser_word;
  assign tx_data = ((state_q == ST_RESP) || (state_q == ST_RESP_WAIT)) ? resp_q : ser_byte;
  assign cpu_rst = cpu_rst_q;

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    word_idx_d    = word_idx_q;
    nak_d         = nak_q;
    resp_d        = resp_q;
    item_d        = item_q;
    pc_snap_d     = pc_snap_q;
    cnt_snap_d    = cnt_snap_q;
    cpu_rst_d     = 1'b0;
    tx_start      = 1'b0;
    cpu_enable    = 1'b0;
    im_we         = 1'b0;
    ser_load      = 1'b0;
    ser_load_word = '0;
    ser_shift     = 1'b0;
    ser_shift_in  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            OP_LOAD: state_d = ST_LOAD_CNT;
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: state_d = ST_STEP;
            OP_DUMP: begin
              item_d  = '0;
              state_d = ST_DUMP_ADDR;
            end
            OP_CPURST: begin
              cpu_rst_d = 1'b1;
              resp_d    = RSP_ACK;
              state_d   = ST_RESP;
            end
            default: begin
              resp_d  = RSP_NAK;
              state_d = ST_RESP;
            end
          endcase
        end
      end

      ST_LOAD_CNT: begin
        if (rx_done) begin
          ser_load   = 1'b1;
          word_cnt_d = rx_data;
          word_idx_d = '0;
          nak_d      = 1'b0;
          if (rx_data == 8'd0) begin
            resp_d  = RSP_ACK;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LOAD_BYTE;
          end
        end
      end

      ST_LOAD_BYTE: begin
        if (rx_done) begin
          ser_shift    = 1'b1;
          ser_shift_in = 1'b1;
          if (ser_last) state_d = ST_LOAD_WRITE;
        end
      end

      ST_LOAD_WRITE: begin
        im_we      = idx_in_range;
        word_idx_d = word_idx_q + 8'd1;
        nak_d      = nak_q || !idx_in_range;
        if ((word_idx_q + 8'd1) == word_cnt_q) begin
          resp_d  = (nak_q || !idx_in_range) ? RSP_NAK : RSP_ACK;
          state_d = ST_RESP;
        end else begin
          state_d = ST_LOAD_BYTE;
        end
      end

      // Enable is gated by halt_flag directly so the halting cycle never clocks the CPU.
      ST_RUN: begin
        cpu_enable = !halt_flag;
        if (halt_flag || (rx_done && (rx_data == OP_BREAK))) begin
          item_d  = '0;
          state_d = ST_DUMP_ADDR;
        end
      end

      ST_STEP: begin
        cpu_enable = !halt_flag;
        item_d     = '0;
        state_d    = ST_DUMP_ADDR;
      end

      ST_DUMP_ADDR: begin
        if (item_q == '0) begin
          pc_snap_d  = DATA_WIDTH'(current_pc);
          cnt_snap_d = DATA_WIDTH'(clock_count);
        end
        state_d = ST_DUMP_LOAD;
      end

      ST_DUMP_LOAD: begin
        ser_load = 1'b1;
        if (item_q == IW'(0))      ser_load_word = pc_snap_q;
        else if (item_q == IW'(1)) ser_load_word = cnt_snap_q;
        else if (item_is_rb)       ser_load_word = rb_data;
        else                       ser_load_word = dm_data;
        state_d = ST_DUMP_BYTE;
      end

      ST_DUMP_BYTE: begin
        tx_start = 1'b1;
        state_d  = ST_DUMP_WAIT;
      end

      ST_DUMP_WAIT: begin
        if (tx_done) begin
          ser_shift = 1'b1;
          if (!ser_last) begin
            state_d = ST_DUMP_BYTE;
          end else if (item_q == IW'(N_ITEMS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            item_d  = item_q + IW'(1);
            state_d = ST_DUMP_ADDR;
          end
        end
      end

      ST_RESP: begin
        tx_start = 1'b1;
        state_d  = ST_RESP_WAIT;
      end

      ST_RESP_WAIT: begin
        if (tx_done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      nak_q      <= 1'b0;
      resp_q     <= '0;
      item_q     <= '0;
      pc_snap_q  <= '0;
      cnt_snap_q <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      word_idx_q <= word_idx_d;
      nak_q      <= nak_d;
      resp_q     <= resp_d;
      item_q     <= item_d;
      pc_snap_q  <= pc_snap_d;
      cnt_snap_q <= cnt_snap_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

endmodule
